eth_rx_hdr_strip: RTL

//  Ethernet RX formatter between the MAC RX stream and the NoC output stage (eth_rx_noc_out).

---
 rtl/eth_rx_hdr_strip_if.sv | 73 +++++++
 rtl/eth_rx_hdr_strip.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_hdr_strip_if.sv
// ----------------------------------------------------------------------------
// eth_rx_hdr_strip_if
//   Bundles the three streams around the Ethernet RX header stripper:
//     - MAC RX beat stream (val/rdy, start/end markers, frame size, padbytes)
//     - header channel towards eth_rx_noc_out (val/rdy, 112-bit header, size)
//     - payload channel towards eth_rx_noc_out (val/rdy, data, last, padbytes)
//     - runt_drop_cnt status counter
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where both val and rdy are 1. A producer holding val=1 keeps its payload
// stable until that edge. rdy may change freely while val=0.
//
// Modports:
//   master : environment side (drives MAC beats and downstream readies)
//   slave  : the stripper itself
// ----------------------------------------------------------------------------
interface eth_rx_hdr_strip_if #(
    parameter int DATA_W = 512,
    parameter int SIZE_W = 16
);
    localparam int PAD_W = $clog2(DATA_W / 8);

    // MAC RX side
    logic              mac_eth_rx_val;
    logic [DATA_W-1:0] mac_eth_rx_data;
    logic              mac_eth_rx_startframe;
    logic [SIZE_W-1:0] mac_eth_rx_frame_size;
    logic              mac_eth_rx_endframe;
    logic [PAD_W-1:0]  mac_eth_rx_padbytes;
    logic              eth_rx_mac_rdy;

    // Header channel
    logic              eth_format_eth_rx_out_hdr_val;
    logic [111:0]      eth_format_eth_rx_out_eth_hdr;
    logic [SIZE_W-1:0] eth_format_eth_rx_out_data_size;
    logic              eth_rx_out_eth_format_hdr_rdy;

    // Payload channel
    logic              eth_format_eth_rx_out_data_val;
    logic [DATA_W-1:0] eth_format_eth_rx_out_data;
    logic              eth_format_eth_rx_out_data_last;
    logic [PAD_W-1:0]  eth_format_eth_rx_out_data_padbytes;
    logic              eth_rx_out_eth_format_data_rdy;

    // Status
    logic [31:0]       runt_drop_cnt;

    modport master (
        output mac_eth_rx_val, mac_eth_rx_data, mac_eth_rx_startframe,
               mac_eth_rx_frame_size, mac_eth_rx_endframe, mac_eth_rx_padbytes,
        input  eth_rx_mac_rdy,
        input  eth_format_eth_rx_out_hdr_val, eth_format_eth_rx_out_eth_hdr,
               eth_format_eth_rx_out_data_size,
        output eth_rx_out_eth_format_hdr_rdy,
        input  eth_format_eth_rx_out_data_val, eth_format_eth_rx_out_data,
               eth_format_eth_rx_out_data_last, eth_format_eth_rx_out_data_padbytes,
        output eth_rx_out_eth_format_data_rdy,
        input  runt_drop_cnt
    );

    modport slave (
        input  mac_eth_rx_val, mac_eth_rx_data, mac_eth_rx_startframe,
               mac_eth_rx_frame_size, mac_eth_rx_endframe, mac_eth_rx_padbytes,
        output eth_rx_mac_rdy,
        output eth_format_eth_rx_out_hdr_val, eth_format_eth_rx_out_eth_hdr,
               eth_format_eth_rx_out_data_size,
        input  eth_rx_out_eth_format_hdr_rdy,
        output eth_format_eth_rx_out_data_val, eth_format_eth_rx_out_data,
               eth_format_eth_rx_out_data_last, eth_format_eth_rx_out_data_padbytes,
        input  eth_rx_out_eth_format_data_rdy,
        output runt_drop_cnt
    );
endinterface

// File: rtl/eth_rx_hdr_strip.sv
// ----------------------------------------------------------------------------
// eth_rx_hdr_strip
//   Ethernet RX formatter between the MAC RX stream and eth_rx_noc_out.
//   The 14-byte Ethernet header {dst, src, eth_type} is taken from the first
//   beat of a frame and offered with the payload byte count on the header
//   channel. The payload is then streamed realigned so payload byte 0 sits at
//   the MSBs of the output beat.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous reset, active low
//   bus        eth_rx_hdr_strip_if.slave (MAC RX in, header out, payload out,
//              runt_drop_cnt)
//   dbg_state  current FSM state (0 IDLE, 1 HDR_OUT, 2 PAYLOAD, 3 FLUSH, 4 DROP)
//
// Build option:
//   ETH_RX_RUNT_DROP_EN  when defined, frames with 14 < frame_size < 60 are
//                        dropped and counted in runt_drop_cnt (saturating).
//                        When undefined they are forwarded and the counter is 0.
//   Frames with frame_size <= 14 are always dropped and never counted.
// ----------------------------------------------------------------------------
module eth_rx_hdr_strip #(
    parameter int DATA_W = 512,
    parameter int SIZE_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    eth_rx_hdr_strip_if.slave      bus,
    output logic [2:0]             dbg_state
);
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int PAD_W      = $clog2(DATA_BYTES);
    localparam int HDR_W      = 112;
    localparam int CARRY_W    = DATA_W - HDR_W;

    localparam logic [SIZE_W-1:0] HDR_BYTES    = SIZE_W'(14);
    // padbytes >= DATA_BYTES-14 on the last input beat means at most 14 valid
    // bytes, all of which fit in the current output beat behind the carry.
    localparam logic [PAD_W-1:0]  LAST_PAD_MIN = PAD_W'(DATA_BYTES - 14);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_OUT = 3'd1,
        PAYLOAD = 3'd2,
        FLUSH   = 3'd3,
        DROP    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [HDR_W-1:0]     hdr_q, hdr_d;
    logic [SIZE_W-1:0]    data_size_q, data_size_d;
    logic [CARRY_W-1:0]   carry_q, carry_d;
    logic                 first_end_q, first_end_d;

    logic                 mac_rdy;
    logic                 hdr_val;
    logic                 data_val;
    logic [DATA_W-1:0]    data_out;
    logic                 data_last;
    logic [PAD_W-1:0]     data_pad;

    logic                 start_acc;
    logic                 size_le_hdr;
    logic                 size_runt;
    logic                 beat_last;
    logic [PAD_W-1:0]     pad_last;

    assign start_acc   = (state_q == IDLE) && bus.mac_eth_rx_val && bus.mac_eth_rx_startframe;
    assign size_le_hdr = bus.mac_eth_rx_frame_size <= HDR_BYTES;

`ifdef ETH_RX_RUNT_DROP_EN
    assign size_runt = !size_le_hdr && (bus.mac_eth_rx_frame_size < SIZE_W'(60));
`else
    assign size_runt = 1'b0;
`endif

    // (DATA_BYTES - size mod DATA_BYTES) mod DATA_BYTES, done in PAD_W bits.
    assign pad_last  = PAD_W'(0) - data_size_q[PAD_W-1:0];
    assign beat_last = bus.mac_eth_rx_endframe && (bus.mac_eth_rx_padbytes >= LAST_PAD_MIN);

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        data_size_d = data_size_q;
        carry_d     = carry_q;
        first_end_d = first_end_q;
        mac_rdy     = 1'b0;
        hdr_val     = 1'b0;
        data_val    = 1'b0;
        data_out    = '0;
        data_last   = 1'b0;
        data_pad    = '0;

        case (state_q)
            IDLE: begin
                mac_rdy = 1'b1;
                if (start_acc) begin
                    if (size_le_hdr || size_runt) begin
                        state_d = bus.mac_eth_rx_endframe ? IDLE : DROP;
                    end else begin
                        hdr_d       = bus.mac_eth_rx_data[DATA_W-1 -: HDR_W];
                        data_size_d = bus.mac_eth_rx_frame_size - HDR_BYTES;
                        carry_d     = bus.mac_eth_rx_data[CARRY_W-1:0];
                        first_end_d = bus.mac_eth_rx_endframe;
                        state_d     = HDR_OUT;
                    end
                end
            end

            HDR_OUT: begin
                hdr_val = 1'b1;
                if (bus.eth_rx_out_eth_format_hdr_rdy) begin
                    state_d = first_end_q ? FLUSH : PAYLOAD;
                end
            end

            PAYLOAD: begin
                // Beats pass straight through; the stored carry supplies the
                // leading bytes and the new beat's top 14 bytes complete it.
                mac_rdy   = bus.eth_rx_out_eth_format_data_rdy;
                data_val  = bus.mac_eth_rx_val;
                data_out  = {carry_q, bus.mac_eth_rx_data[DATA_W-1 -: HDR_W]};
                data_last = beat_last;
                data_pad  = beat_last ? pad_last : '0;
                if (bus.mac_eth_rx_val && bus.eth_rx_out_eth_format_data_rdy) begin
                    carry_d = bus.mac_eth_rx_data[CARRY_W-1:0];
                    if (bus.mac_eth_rx_endframe) begin
                        state_d = beat_last ? IDLE : FLUSH;
                    end
                end
            end

            FLUSH: begin
                data_val  = 1'b1;
                data_out  = {carry_q, {HDR_W{1'b0}}};
                data_last = 1'b1;
                data_pad  = pad_last;
                if (bus.eth_rx_out_eth_format_data_rdy) begin
                    state_d = IDLE;
                end
            end

            DROP: begin
                mac_rdy = 1'b1;
                if (bus.mac_eth_rx_val && bus.mac_eth_rx_endframe) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hdr_q       <= '0;
            data_size_q <= '0;
            carry_q     <= '0;
            first_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            data_size_q <= data_size_d;
            carry_q     <= carry_d;
            first_end_q <= first_end_d;
        end
    end

`ifdef ETH_RX_RUNT_DROP_EN
    logic [31:0] runt_cnt_q, runt_cnt_d;

    always_comb begin
        runt_cnt_d = runt_cnt_q;
        if (start_acc && size_runt && (runt_cnt_q != 32'hFFFF_FFFF)) begin
            runt_cnt_d = runt_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            runt_cnt_q <= '0;
        end else begin
            runt_cnt_q <= runt_cnt_d;
        end
    end

    assign bus.runt_drop_cnt = runt_cnt_q;
`else
    assign bus.runt_drop_cnt = 32'd0;
`endif

    assign bus.eth_rx_mac_rdy                      = mac_rdy;
    assign bus.eth_format_eth_rx_out_hdr_val       = hdr_val;
    assign bus.eth_format_eth_rx_out_eth_hdr       = hdr_q;
    assign bus.eth_format_eth_rx_out_data_size     = data_size_q;
    assign bus.eth_format_eth_rx_out_data_val      = data_val;
    assign bus.eth_format_eth_rx_out_data          = data_out;
    assign bus.eth_format_eth_rx_out_data_last     = data_last;
    assign bus.eth_format_eth_rx_out_data_padbytes = data_pad;
    assign dbg_state                               = state_q;

endmodule
